// File: rtl/mult32_sequencer.sv
// rtl/mult32_sequencer.sv - valid/ready sequencer around the mult32 shift-add core with signed support
module mult32_sequencer #(
    parameter int CORE_RST_CYCLES = 2,
    parameter int MULT_LATENCY    = 34
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_product,
    output logic        busy,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_reset,
    input  logic [63:0] core_result
);

    localparam int CNT_MAX = (CORE_RST_CYCLES > MULT_LATENCY) ? CORE_RST_CYCLES : MULT_LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic          neg;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        neg_next;

    // The core is unsigned, so signed operands are fed as magnitudes and the sign reapplied at capture.
    always_comb begin
        mag_a    = (in_signed && in_a[31]) ? -in_a : in_a;
        mag_b    = (in_signed && in_b[31]) ? -in_b : in_b;
        neg_next = in_signed && (in_a[31] ^ in_b[31]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            neg         <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_product <= '0;
            busy        <= 1'b0;
            core_a      <= '0;
            core_b      <= '0;
            core_reset  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        neg      <= neg_next;
                        core_a   <= mag_a;
                        core_b   <= mag_b;
                        counter  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (counter == CW'(CORE_RST_CYCLES - 1)) begin
                        counter    <= '0;
                        core_reset <= 1'b0;
                        state      <= RUN;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                RUN: begin
                    // Counter reaches MULT_LATENCY once the core has had that many active cycles.
                    if (counter == CW'(MULT_LATENCY)) begin
                        out_product <= neg ? -core_result : core_result;
                        out_valid   <= 1'b1;
                        core_reset  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
